dmem_access_unit: RTL
=====================

// Module: dmem_access_unit
// PURPOSE
//  Load/store executor for the RV32I core. Consumes the decoded memory controls
//  (mem_write, lwhb/swhb size code, l_unsigned) plus address/store data, runs one
//  handshaked word-bus transaction, and returns sign/zero-extended load data.
//  Sits between the EX stage and the data-memory bus; stalls the core while busy.
// PARAMETERS
//  ADDR_W          32   byte-address width
//  TIMEOUT_CYCLES  16   max cycles waiting for bus_ack (only with DMEM_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  req_valid    in   1   core presents a load/store this cycle
//  req_ready    out  1   unit idle, request accepted when req_valid&req_ready
//  mem_write    in   1   1=store, 0=load
//  size         in   2   `SL_W=2'b00, `SL_H=2'b01, `SL_B=2'b10 (2'b11 = SL_W)
//  l_unsigned   in   1   load zero-extends when 1, sign-extends when 0
//  addr         in   ADDR_W  byte address
//  wdata        in   32  store data, right-aligned
//  resp_valid   out  1   one-cycle pulse: access finished
//  resp_rdata   out  32  extended load data (0 for stores/errors)
//  resp_err     out  1   valid with resp_valid: misaligned or timeout
//  bus_req      out  1   bus request, held until bus_ack
//  bus_we       out  1   bus write enable
//  bus_addr     out  ADDR_W  word-aligned address (addr[1:0]=0)
//  bus_be       out  4   byte lane enables
//  bus_wdata    out  32  lane-steered store data
//  bus_ack      in   1   bus completes transaction; bus_rdata valid same cycle
//  bus_rdata    in   32  raw word read data
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0,
//    bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
//  - FSM IDLE -> BUS -> RESP -> IDLE. req_ready=1 only in IDLE.
//  - IDLE: on accept, register request. Aligned: -> BUS. Misaligned (H with
//    addr[0]=1, W with addr[1:0]!=0): no bus access, -> RESP with err=1.
//  - BUS: bus_req=1, bus_we/addr/be/wdata stable from registered request until
//    bus_ack. On bus_ack: capture bus_rdata, -> RESP.
//  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
//  - Latency (aligned, ack in first BUS cycle): accept cycle 0, bus_req cycle 1,
//    resp_valid cycle 2. Each extra wait cycle adds one.
//  - Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<addr[1]*2; W -> 4'b1111.
//  - Store data: B replicated to all lanes {4{wdata[7:0]}}; H {2{wdata[15:0]}}.
//  - Load: select lane by addr[1:0], extend per l_unsigned. Stores: resp_rdata=0.
//  - Errors: resp_rdata=0.
//  - bus_ack outside BUS is ignored. req_valid outside IDLE is ignored (not queued).
//  - rst asserted mid-transaction: bus_req drops asynchronously, state IDLE,
//    no resp_valid for the aborted access.
// CONFIGURATION
//  DMEM_TIMEOUT_EN defined: down-counter loaded with TIMEOUT_CYCLES on entry to
//    BUS; if it reaches 0 without bus_ack, drop bus_req, -> RESP with err=1.
//    An ack in the expiry cycle wins (normal completion).
//  Undefined: no counter; BUS waits indefinitely for bus_ack.
// STRUCTURE
//  Define.v: SL_W/SL_H/SL_B size codes, FSM state encodings, DMEM_BE_* masks.
//  Sub-module dmem_align (combinational): size+addr[1:0]+wdata -> be/wdata/misalign;
//    size+addr[1:0]+l_unsigned+rdata -> extended load data. Top holds FSM/regs.
// TESTING
//  1 sw addr=0x100 wdata=0xDEADBEEF, ack on 1st BUS cycle -> be=1111,
//    bus_addr=0x100, we=1, resp_valid at cycle 2, err=0.
//  2 lb addr=0x103, rdata=0x80FF_FF00, l_unsigned=0 -> resp_rdata=0xFFFFFF80;
//    same with lbu -> 0x00000080.
//  3 sh addr=0x102 wdata=0x1234 -> be=1100, bus_wdata=0x12341234; lh addr=0x101
//    -> no bus_req, resp_err=1, resp_rdata=0.
//  4 lw with ack delayed 5 cycles -> bus_req/addr stable 5+ cycles, req_ready=0,
//    resp_valid one cycle after ack; req_valid during BUS ignored.
//  5 rst pulse while bus_req=1 -> bus_req=0 immediately, no resp_valid, next
//    request serviced normally; stray ack in IDLE has no effect.
//  6 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 cycles,
//    resp_err=1; ack on 4th cycle -> normal response, err=0.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states,
// base byte-enable masks and the registered request record.
package dmem_access_unit_pkg;

    localparam logic [1:0] SL_W = 2'b00;
    localparam logic [1:0] SL_H = 2'b01;
    localparam logic [1:0] SL_B = 2'b10;

    localparam logic [3:0] DMEM_BE_B = 4'b0001;
    localparam logic [3:0] DMEM_BE_H = 4'b0011;
    localparam logic [3:0] DMEM_BE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic [1:0] addr_lo;
        logic       l_unsigned;
    } req_t;

endpackage

// File: rtl/dmem_access_unit_align.sv
// Lane steering for the access unit: byte enables, replicated store data, misalignment
// detection and load-data extraction with sign/zero extension. Purely combinational.
module dmem_access_unit_align
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        l_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        misalign,
    output logic [31:0] load_data
);

    logic [31:0] rd_shift;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_shift = rdata >> {addr_lo, 3'b000};
    assign rd_byte  = rd_shift[7:0];
    assign rd_half  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = DMEM_BE_W;
        lane_wdata = wdata;
        misalign   = 1'b0;
        load_data  = rdata;
        case (size)
            SL_B: begin
                be         = DMEM_BE_B << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                load_data  = l_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            end
            SL_H: begin
                be         = DMEM_BE_H << {addr_lo[1], 1'b0};
                lane_wdata = {2{wdata[15:0]}};
                misalign   = addr_lo[0];
                load_data  = l_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            end
            // 2'b11 is treated as a word access
            default: begin
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store executor: one handshaked word-bus transaction per request, extended load data back.
// Latency 2 cycles accept->resp_valid with immediate ack; stalls (req_ready=0) until response done.
// Optional macro DMEM_TIMEOUT_EN bounds the wait for bus_ack to TIMEOUT_CYCLES and reports an error.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef DMEM_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              l_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    state_t      state;
    req_t        req;
    logic        idle;
    logic [1:0]  al_size;
    logic [1:0]  al_addr_lo;
    logic        al_unsigned;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_load;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;
`endif

    // One aligner serves both directions: live request while idle, latched request afterwards.
    assign idle        = (state == ST_IDLE);
    assign al_size     = idle ? size            : req.size;
    assign al_addr_lo  = idle ? addr[1:0]       : req.addr_lo;
    assign al_unsigned = idle ? l_unsigned      : req.l_unsigned;

    dmem_access_unit_align u_align (
        .size       (al_size),
        .addr_lo    (al_addr_lo),
        .l_unsigned (al_unsigned),
        .wdata      (wdata),
        .rdata      (bus_rdata),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .misalign   (al_misalign),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            req        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'd0;
            bus_wdata  <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req.we         <= mem_write;
                        req.size       <= size;
                        req.addr_lo    <= addr[1:0];
                        req.l_unsigned <= l_unsigned;
                        req_ready      <= 1'b0;
                        if (al_misalign) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= ST_BUS;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
`ifdef DMEM_TIMEOUT_EN
                            tmo_cnt   <= CNT_W'(TIMEOUT_CYCLES);
`endif
                        end
                    end
                end
                ST_BUS: begin
                    // An ack arriving in the expiry cycle still completes normally.
                    if (bus_ack) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= req.we ? 32'd0 : al_load;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_be     <= 4'd0;
                        bus_wdata  <= 32'd0;
                    end
`ifdef DMEM_TIMEOUT_EN
                    else if (tmo_cnt <= CNT_W'(1)) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                        bus_req    <= 1'b0;
                        bus_we     <= 1'b0;
                        bus_addr   <= '0;
                        bus_be     <= 4'd0;
                        bus_wdata  <= 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt - CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
